// File: rtl/ram_stream_reader_if.sv
// Bus bundle between the RAM stream reader and its environment: command
// strobe and status, RAM read port, and the valid/ready output stream.
interface ram_stream_reader_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              start;
    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] ram_read_addr;
    logic [DATA_W-1:0] ram_data_out;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    // Reader side: drives status, the RAM address and the output stream.
    modport master (
        input  start, start_addr, count, ram_data_out, out_ready,
        output busy, done, ram_read_addr, out_data, out_valid
    );

    // Environment side: issues commands, returns RAM data, consumes the stream.
    modport slave (
        output start, start_addr, count, ram_data_out, out_ready,
        input  busy, done, ram_read_addr, out_data, out_valid
    );
endinterface

// File: rtl/ram_stream_reader.sv
// Read-side controller for a 2^ADDR_W x DATA_W RAM with a one-cycle registered
// read. Walks a wrapping address range and streams the words out in address
// order through a 2-entry skid buffer that hides the RAM latency and absorbs
// backpressure.
module ram_stream_reader #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset_n,
    ram_stream_reader_if.master bus
);
    localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(1 << ADDR_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] addr_ptr_q;
    logic [ADDR_W:0]   remaining_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;

    logic [DATA_W-1:0] buf_mem_q [2];
    logic              head_q;
    logic              head_d;
    logic [1:0]        buf_count_q;
    logic [1:0]        buf_count_d;

    logic              pop;
    logic              push;
    logic              issue;
    logic              drained;
    logic              tail;
    logic [2:0]        occ_after_pop;
    logic [ADDR_W:0]   count_clamped;

    // A word leaves the buffer whenever the consumer accepts the current head.
    assign pop  = (buf_count_q != 2'd0) && bus.out_ready;
    // The word requested last cycle is on the RAM output now.
    assign push = inflight_q;

    // Only request a new word if it is guaranteed a buffer slot when it lands.
    assign occ_after_pop = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign issue = (state_q == READ) && (remaining_q != '0) && (occ_after_pop < 3'd2);

    assign buf_count_d = buf_count_q + {1'b0, push} - {1'b0, pop};
    assign head_d      = head_q ^ pop;
    // With two entries the free slot is head when empty or full, else the other one.
    assign tail        = head_q ^ buf_count_q[0];

    // Nothing left to request, nothing on the way, buffer empty after this edge.
    assign drained = (remaining_q == '0) && !inflight_q && (buf_count_d == 2'd0);

    assign count_clamped = (bus.count > DEPTH) ? DEPTH : bus.count;

    assign bus.ram_read_addr = addr_ptr_q;
    assign bus.out_valid     = (buf_count_q != 2'd0);
    assign bus.out_data      = buf_mem_q[head_q];
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

    // Command FSM: accepts a command in IDLE, walks the addresses in READ,
    // and spends exactly one cycle in DONE to pulse done.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            addr_ptr_q  <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= issue;
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        if (count_clamped != '0) begin
                            addr_ptr_q  <= bus.start_addr;
                            remaining_q <= count_clamped;
                            busy_q      <= 1'b1;
                            state_q     <= READ;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                READ: begin
                    if (issue) begin
                        addr_ptr_q  <= addr_ptr_q + ADDR_W'(1);
                        remaining_q <= remaining_q - (ADDR_W + 1)'(1);
                    end
                    if (drained) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Skid buffer: capture the RAM word at the tail, retire the head on a pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            buf_mem_q[0] <= '0;
            buf_mem_q[1] <= '0;
            head_q       <= 1'b0;
            buf_count_q  <= 2'd0;
        end else begin
            if (push) begin
                buf_mem_q[tail] <= bus.ram_data_out;
            end
            head_q      <= head_d;
            buf_count_q <= buf_count_d;
        end
    end

    // The issue rule must never let a captured word find the buffer full.
    assert property (@(posedge clk) disable iff (!reset_n)
        !(push && !pop && (buf_count_q == 2'd2)));

endmodule

// File: tb/tb_ram_stream_reader.sv
// Self-checking bench for ram_stream_reader: a RAM model with registered read,
// a queue-based reference of the expected word stream and status timing,
// directed scenarios with literal expectations, then randomized commands.
module tb_ram_stream_reader;
    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic clk     = 1'b0;
    logic reset_n = 1'b1;
    always #5 clk = ~clk;

    ram_stream_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    ram_stream_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // RAM model with one-cycle registered read.
    logic [DATA_W-1:0] ram [DEPTH];
    logic [DATA_W-1:0] ram_rd_q;
    always @(posedge clk) ram_rd_q <= ram[bus.ram_read_addr];
    assign bus.ram_data_out = ram_rd_q;

    int tests_run    = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    bit                m_active   = 1'b0;
    bit                m_done_now = 1'b0;
    bit                m_idle_now;
    int                m_age      = 0;
    logic [ADDR_W-1:0] m_start_addr = '0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] got_q[$];
    bit                m_exp_valid;
    int                m_n;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_active   = 1'b0;
            m_done_now = 1'b0;
            exp_q.delete();
            check("rst_busy",  32'(bus.busy),          32'd0);
            check("rst_done",  32'(bus.done),          32'd0);
            check("rst_valid", 32'(bus.out_valid),     32'd0);
            check("rst_data",  32'(bus.out_data),      32'd0);
            check("rst_addr",  32'(bus.ram_read_addr), 32'd0);
        end else begin
            if (m_active) m_age++;
            m_exp_valid = m_active && (m_age >= 3);
            check("busy",  32'(bus.busy),      32'(m_active));
            check("done",  32'(bus.done),      32'(m_done_now));
            check("valid", 32'(bus.out_valid), 32'(m_exp_valid));
            if (m_exp_valid && exp_q.size() > 0)
                check("data", 32'(bus.out_data), 32'(exp_q[0]));
            if (m_active && m_age == 1)
                check("first_addr", 32'(bus.ram_read_addr), 32'(m_start_addr));

            // advance the model to the next edge
            m_idle_now = !m_active && !m_done_now;
            m_done_now = 1'b0;
            if (m_exp_valid && bus.out_ready) begin
                got_q.push_back(bus.out_data);
                $display("[TB] xfer #%0d data=%02h", got_q.size(), bus.out_data);
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                if (exp_q.size() == 0) begin
                    m_active   = 1'b0;
                    m_done_now = 1'b1;
                end
            end else if (m_idle_now && bus.start) begin
                m_n = (int'(bus.count) > DEPTH) ? DEPTH : int'(bus.count);
                exp_q.delete();
                for (int i = 0; i < m_n; i++)
                    exp_q.push_back(ram[ADDR_W'(int'(bus.start_addr) + i)]);
                if (m_n > 0) begin
                    m_active     = 1'b1;
                    m_age        = 0;
                    m_start_addr = bus.start_addr;
                end else begin
                    m_done_now = 1'b1;
                end
            end
        end
    end

    // ---------------- out_ready driver ----------------
    int         ready_mode = 0;       // 0 always, 1 random, 2 fixed pattern
    logic [7:0] ready_pat  = 8'b01101001;  // 1,0,0,1,0,1,1,0 from bit 0
    initial begin
        int pidx;
        pidx = 0;
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       bus.out_ready = 1'b1;
                1:       bus.out_ready = 1'($urandom_range(0, 1));
                default: bus.out_ready = ready_pat[pidx % 8];
            endcase
            pidx++;
        end
    end

    // ---------------- command task ----------------
    logic [ADDR_W-1:0] addr_log [32];

    task automatic run_cmd(input logic [ADDR_W-1:0] sa, input logic [ADDR_W:0] n,
                           input bit hold2, input int pulse_age, output int done_age);
        int age;
        bit seen;
        bit drop_pending;
        @(posedge clk);
        #1;
        got_q.delete();
        bus.start      = 1'b1;
        bus.start_addr = sa;
        bus.count      = n;
        @(posedge clk);           // start edge
        #1;
        bus.start_addr = ADDR_W'($urandom);
        bus.count      = (ADDR_W + 1)'($urandom);
        drop_pending   = hold2;
        if (!hold2) bus.start = 1'b0;
        age  = 0;
        seen = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            age++;
            if (age < 32) addr_log[age] = bus.ram_read_addr;
            if (bus.done) seen = 1'b1;
            if (!seen) begin
                if (drop_pending) begin
                    @(posedge clk);
                    #1;
                    bus.start    = 1'b0;
                    drop_pending = 1'b0;
                end else if (age == pulse_age) begin
                    @(posedge clk);
                    #1;
                    bus.start      = 1'b1;
                    bus.start_addr = ADDR_W'($urandom);
                    bus.count      = (ADDR_W + 1)'($urandom_range(1, 16));
                    drop_pending   = 1'b1;
                end
            end
        end
        if (drop_pending) begin
            @(posedge clk);
            #1;
            bus.start = 1'b0;
        end
        if (!seen) check("done_timeout", 32'd0, 32'd1);
        done_age = age;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int age;
        int exp_n;
        bit got3;
        logic [ADDR_W-1:0] sa;
        logic [ADDR_W:0]   n;

        bus.start      = 1'b0;
        bus.start_addr = '0;
        bus.count      = '0;
        for (int i = 0; i < DEPTH; i++) ram[i] = '0;

        // reset state
        #1 reset_n = 1'b0;
        #1;
        check("por_busy",  32'(bus.busy),          32'd0);
        check("por_valid", 32'(bus.out_valid),     32'd0);
        check("por_addr",  32'(bus.ram_read_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;

        // scenario 1: 4 words from address 0, consumer always ready
        ram[0] = 8'h10; ram[1] = 8'h11; ram[2] = 8'h12; ram[3] = 8'h13;
        ready_mode = 0;
        run_cmd(4'd0, 5'd4, 1'b0, -1, age);
        check("s1_done_age", 32'(age), 32'd7);
        check("s1_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("s1_word", 32'(got_q[i]), 32'h10 + 32'(i));

        // scenario 2: wrap from 14
        ram[14] = 8'hAE; ram[15] = 8'hAF; ram[0] = 8'hA0; ram[1] = 8'hA1;
        run_cmd(4'd14, 5'd4, 1'b0, -1, age);
        check("s2_addr1", 32'(addr_log[1]), 32'd14);
        check("s2_addr2", 32'(addr_log[2]), 32'd15);
        check("s2_addr3", 32'(addr_log[3]), 32'd0);
        check("s2_addr4", 32'(addr_log[4]), 32'd1);
        check("s2_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() == 4) begin
            check("s2_w0", 32'(got_q[0]), 32'hAE);
            check("s2_w1", 32'(got_q[1]), 32'hAF);
            check("s2_w2", 32'(got_q[2]), 32'hA0);
            check("s2_w3", 32'(got_q[3]), 32'hA1);
        end

        // scenario 3: 8 words under a fixed backpressure pattern
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
        ready_mode = 2;
        run_cmd(4'd3, 5'd8, 1'b0, -1, age);
        check("s3_count", 32'(got_q.size()), 32'd8);
        for (int i = 0; i < 8 && i < got_q.size(); i++)
            check("s3_word", 32'(got_q[i]), 32'(ram[4'(3 + i)]));

        // scenario 4: zero-length command
        ready_mode = 0;
        run_cmd(4'd7, 5'd0, 1'b0, -1, age);
        check("s4_done_age", 32'(age), 32'd1);
        check("s4_count", 32'(got_q.size()), 32'd0);

        // scenario 5: full 16-word sweep from 5 with an ignored mid-stream start
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'hC0 + 8'(i);
        ready_mode = 1;
        run_cmd(4'd5, 5'd16, 1'b0, 6, age);
        check("s5_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++)
            check("s5_word", 32'(got_q[i]), 32'hC0 + 32'((5 + i) % 16));

        // scenario 6: reset after 3 of 8 words
        for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
        ready_mode = 2;
        @(posedge clk);
        #1;
        got_q.delete();
        bus.start = 1'b1; bus.start_addr = 4'd0; bus.count = 5'd8;
        @(posedge clk);
        #1 bus.start = 1'b0;
        got3 = 1'b0;
        for (int c = 0; c < 100 && !got3; c++) begin
            @(negedge clk);
            #1;
            if (got_q.size() >= 3) got3 = 1'b1;
        end
        if (!got3) check("s6_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("s6_busy",  32'(bus.busy),          32'd0);
        check("s6_valid", 32'(bus.out_valid),     32'd0);
        check("s6_data",  32'(bus.out_data),      32'd0);
        check("s6_addr",  32'(bus.ram_read_addr), 32'd0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check("s6_count", 32'(got_q.size()), 32'd3);

        ram[0] = 8'h10; ram[1] = 8'h11; ram[2] = 8'h12; ram[3] = 8'h13;
        ready_mode = 0;
        run_cmd(4'd0, 5'd4, 1'b0, -1, age);
        check("s6b_done_age", 32'(age), 32'd7);
        check("s6b_count", 32'(got_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            check("s6b_word", 32'(got_q[i]), 32'h10 + 32'(i));

        // randomized commands
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < DEPTH; i++) ram[i] = 8'($urandom);
            ready_mode = $urandom_range(0, 2);
            sa = ADDR_W'($urandom);
            n  = (ADDR_W + 1)'($urandom_range(0, 20));
            run_cmd(sa, n, 1'($urandom_range(0, 1)), -1, age);
            exp_n = (int'(n) > DEPTH) ? DEPTH : int'(n);
            check("rand_count", 32'(got_q.size()), 32'(exp_n));
            if (exp_n == 0) check("rand_zero_done", 32'(age), 32'd1);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $fatal(1);
    end

endmodule

// File: doc/ram_stream_reader.md
Name: ram_stream_reader

Overview:
- Read-side controller for the 16-word x 8-bit two-port RAM.
- On a start command it walks a contiguous, wrapping address range on the RAM read port and absorbs the RAM's one-cycle registered read latency.
- It presents the words in order on a valid/ready output stream, with full backpressure support.
- It is the consumer-side counterpart to the RAM's write-port producer.

Parameters:
- ADDR_W, 4, RAM address width; depth is 2^ADDR_W = 16.
- DATA_W, 8, RAM word width.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- start  input  1  command strobe; sampled only in IDLE.
- start_addr  input  ADDR_W  first address to read.
- count  input  ADDR_W+1  number of words to read, 0..16; values above 16 are treated as 16.
- busy  output  1  high while a command is in progress.
- done  output  1  one-cycle pulse when a command completes.
- ram_read_addr  output  ADDR_W  drives the RAM read_addr; combinationally equal to the internal address pointer register.
- ram_data_out  input  DATA_W  RAM data_out; valid one clock after an address is presented.
- out_data  output  DATA_W  stream data.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready; a transfer occurs on an edge where out_valid && out_ready.

Behaviour:
- Reset (reset_n low, asynchronous): state=IDLE; busy=0, done=0, out_valid=0, out_data=0, ram_read_addr=0. Buffer, in-flight flag and remaining counter are cleared. A reset mid-command aborts the command; no further output is produced.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - start=1 with count>0 at an edge: latch addr_ptr=start_addr and remaining=count, go to READ, busy=1 from the next cycle.
  - start=1 with count=0: go to DONE directly; no RAM read is issued.
- READ, issue rule:
  - A read is "issued" in a cycle when remaining>0 and (buf_count + inflight - pop) < 2.
  - pop = out_valid && out_ready in that cycle.
  - On an issue: addr_ptr increments modulo 16 (15 wraps to 0), remaining decrements, and inflight is set for the next cycle.
  - With no issue, inflight clears next cycle.
- Capture: in a cycle with inflight=1, ram_data_out is written into a 2-entry FIFO buffer at the closing edge.
- Output: out_valid = buffer non-empty; out_data = buffer head. Ordering is strictly address order.
- Simultaneous capture and pop in the same cycle is legal; occupancy is unchanged.
- The buffer never overflows; the issue rule guarantees this. Any overflow is an assertion failure.
- Latency:
  - With the start edge labelled Es, the first issue is in the cycle after Es. The RAM samples at Es+1 and the buffer captures at Es+2. out_valid rises after Es+2.
  - With out_ready held high, throughput is 1 word per clock.
- Completion: the READ to DONE transition occurs at the edge where remaining=0, inflight=0 and the buffer becomes empty (including via a final pop).
- DONE: lasts exactly one cycle with done=1 and busy=0, then returns to IDLE. start is ignored in DONE.
- start asserted while busy or in DONE is ignored; there is no queuing.
- Changes on start_addr/count after the start edge have no effect.
- out_valid, once high, stays high with out_data stable until popped. This holds even under arbitrary out_ready toggling.

Test Plan:
- Preload RAM[0..3]=0x10,0x11,0x12,0x13; start_addr=0, count=4, out_ready=1 -> out_valid rises 2 clocks after the start edge; words 0x10,0x11,0x12,0x13 on consecutive cycles; done pulses 1 cycle after the last transfer; busy low with done.
- Preload RAM[14]=0xAE, RAM[15]=0xAF, RAM[0]=0xA0, RAM[1]=0xA1; start_addr=14, count=4 -> ram_read_addr sequence 14,15,0,1; output 0xAE,0xAF,0xA0,0xA1.
- count=8 with out_ready pattern 1,0,0,1,0,1,1,0,... -> exactly 8 transfers in order; out_data stable while valid&&!ready; buffer occupancy never exceeds 2; no word lost or duplicated.
- start with count=0 -> no out_valid; done pulses the cycle after the start edge; busy stays 0.
- count=16 from start_addr=5 -> all 16 words delivered (5..15, 0..4); a second start asserted mid-stream is ignored; the final done pulse is a single cycle.
- reset_n low for 1 cycle mid-stream (after 3 of 8 words) -> all outputs 0 immediately; no further out_valid; a new start after release behaves as in the first scenario.
